lu_acc_logic_unit: RTL



---
 rtl/lu_pkg.sv | 13 +
 rtl/lu_core.sv | 25 ++
 rtl/lu_acc_logic_unit.sv | 64 ++++++
 3 files changed

// File: rtl/lu_pkg.sv
// Shared opcode encodings and widths for the accumulating logic unit.
// No logic, no latency, no flow control.
// Pure declarations; nothing here applies back-pressure.
package lu_pkg;

   localparam int SEL_W = 2;

   localparam logic [SEL_W-1:0] OP_XNOR = 2'b00;
   localparam logic [SEL_W-1:0] OP_XOR  = 2'b01;
   localparam logic [SEL_W-1:0] OP_OR   = 2'b10;
   localparam logic [SEL_W-1:0] OP_NOR  = 2'b11;

endpackage

// File: rtl/lu_core.sv
// Bitwise 4-way logic selector across WIDTH bits.
// Latency: 0 cycles, purely combinational.
// No flow control; the caller qualifies the result with its own handshake.
module lu_core
   import lu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [SEL_W-1:0] select,
   output logic [WIDTH-1:0] result
);

   always_comb begin
      result = '0;
      case (select)
         OP_XNOR: result = ~(a ^ b);
         OP_XOR:  result = a ^ b;
         OP_OR:   result = a | b;
         default: result = ~(a | b);
      endcase
   end

endmodule

// File: rtl/lu_acc_logic_unit.sv
// Registered WIDTH-bit logic unit with an accumulator that can stand in for operand b.
// Latency: 1 cycle from accept to result; 1 beat/cycle while out_ready is high.
// Back-pressure: in_ready = !out_valid || out_ready, so a stalled result blocks new beats.
module lu_acc_logic_unit
   import lu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [SEL_W-1:0] select,
   input  logic             use_acc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             zero,
   output logic [WIDTH-1:0] acc,
   output logic [CNT_W-1:0] op_count
);

   logic [WIDTH-1:0] opnd_b;
   logic [WIDTH-1:0] result;
   logic             accept;
   logic             consume;

   // acc here is the pre-edge value, so back-to-back accumulates chain correctly
   assign opnd_b  = use_acc ? acc : b;
   assign in_ready = !out_valid || out_ready;
   assign accept  = in_valid && in_ready;
   assign consume = out_valid && out_ready;

   lu_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .a      (a),
      .b      (opnd_b),
      .select (select),
      .result (result)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         s         <= '0;
         zero      <= 1'b1;
         acc       <= '0;
         op_count  <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         s         <= result;
         zero      <= (result == '0);
         acc       <= result;
         op_count  <= op_count + CNT_W'(1);
      end else if (consume) begin
         out_valid <= 1'b0;
      end
   end

endmodule
